// File: rtl/msb_grant_scheduler_pkg.sv
// Shared types and defaults for the MSB-first grant scheduler.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Contents:
//   state_t          scheduler FSM states
//   DEF_WIDTH        default request vector width
//   DEF_MAX_GRANTS   default cap on grants per start
//   f_pos_w()        position width for a given vector width
package msb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_MAX_GRANTS = 3;

  function automatic int f_pos_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/msb_grant_scheduler_pe.sv
// MSB priority encoder: index of the highest set bit of a vector.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   vec  in   WIDTH   vector to encode
//   pos  out  POS_W   index of the highest set bit (0 when vec is 0)
//   vld  out  1       vec has at least one bit set
module msb_pe #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [POS_W-1:0] pos,
  output logic             vld
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    pos = '0;
    vld = |vec;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) pos = POS_W'(i);
    end
  end

endmodule

// File: rtl/msb_grant_scheduler.sv
// Turns one captured request vector into up to MAX_GRANTS grants, highest bit first.
// Latency: first grant valid the cycle after start is sampled; one grant/cycle when ready.
// Backpressure: out_pos and pending vector hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start, req    capture req and begin a scan (ignored while busy)
//   flush         synchronous abort back to IDLE, no done pulse
//   out_valid/out_ready/out_pos   grant handshake, position of highest pending bit
//   busy          scan in progress (SCAN or DONE)
//   done          one-cycle end-of-scan pulse
//   grant_cnt     grants issued in the last completed scan
//   remain        bits left ungranted at the end of the scan
//   out_onehot    (only with MSB_SCHED_ONEHOT_EN) 1<<out_pos while out_valid, else 0
module msb_grant_scheduler
  import msb_sched_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int POS_W      = f_pos_w(DEF_WIDTH),
  parameter int MAX_GRANTS = DEF_MAX_GRANTS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] req,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
`ifdef MSB_SCHED_ONEHOT_EN
  output logic [WIDTH-1:0] out_onehot,
`endif
  output logic             busy,
  output logic             done,
  output logic [POS_W:0]   grant_cnt,
  output logic [WIDTH-1:0] remain
);

  localparam logic [POS_W:0]   MAX_C = (POS_W+1)'(MAX_GRANTS);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [POS_W:0]   cnt;

  logic             pe_vld;
  logic             hs;
  logic [WIDTH-1:0] pend_nxt;
  logic [POS_W:0]   cnt_nxt;
  logic             last_grant;

  msb_pe #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_pe (
    .vec (pend),
    .pos (out_pos),
    .vld (pe_vld)
  );

  // Decoded purely from registers, so no input-to-output combinational path.
  assign out_valid  = (state == SCAN) && pe_vld && (cnt < MAX_C);
  assign busy       = (state != IDLE);
  assign hs         = out_valid && out_ready;
  assign pend_nxt   = pend & ~(ONE_W << out_pos);
  assign cnt_nxt    = cnt + 1'b1;
  assign last_grant = (pend_nxt == '0) || (cnt_nxt == MAX_C);

`ifdef MSB_SCHED_ONEHOT_EN
  assign out_onehot = out_valid ? (ONE_W << out_pos) : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      grant_cnt <= '0;
      remain    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // flush in IDLE drops a coincident start.
          if (start && !flush) begin
            pend      <= req;
            cnt       <= '0;
            grant_cnt <= '0;
            remain    <= '0;
            if (req == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (flush) begin
            state <= IDLE;
            pend  <= '0;
            cnt   <= '0;
          end else if (hs) begin
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
            if (last_grant) begin
              state     <= DONE;
              done      <= 1'b1;
              remain    <= pend_nxt;
              grant_cnt <= cnt_nxt;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (flush) begin
            pend <= '0;
            cnt  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          pend  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msb_grant_scheduler.sv
module tb_msb_grant_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] req;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_pos;
  logic       busy;
  logic       done;
  logic [3:0] grant_cnt;
  logic [7:0] remain;
`ifdef MSB_SCHED_ONEHOT_EN
  logic [7:0] out_onehot;
`endif

  int tests = 0;
  int fails = 0;

  msb_grant_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .req        (req),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pos    (out_pos),
`ifdef MSB_SCHED_ONEHOT_EN
    .out_onehot (out_onehot),
`endif
    .busy       (busy),
    .done       (done),
    .grant_cnt  (grant_cnt),
    .remain     (remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for exactly one sampling edge.
  task automatic kick(input logic [7:0] r);
    start = 1'b1;
    req   = r;
    step();
    start = 1'b0;
    req   = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; req = 0; flush = 0; out_ready = 0;
    #12;
    tests++;
    if ({out_valid, out_pos, busy, done, grant_cnt, remain} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b pos=%0d busy=%b done=%b cnt=%0d rem=%h want all 0",
               out_valid, out_pos, busy, done, grant_cnt, remain);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [2:0] exp_pos [3] = '{3'd7, 3'd5, 3'd2};
    out_ready = 1'b1;
    kick(8'b1010_0110);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_pos !== exp_pos[i]) begin
        fails++;
        $display("FAIL basic_grant%0d got v=%b pos=%0d want v=1 pos=%0d", i, out_valid, out_pos, exp_pos[i]);
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || grant_cnt !== 4'd3 || remain !== 8'b0000_0010 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_done got done=%b cnt=%0d rem=%h v=%b want done=1 cnt=3 rem=02 v=0",
               done, grant_cnt, remain, out_valid);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || grant_cnt !== 4'd3 || remain !== 8'h02) begin
      fails++;
      $display("FAIL basic_idle got done=%b busy=%b cnt=%0d rem=%h want done=0 busy=0 cnt=3 rem=02",
               done, busy, grant_cnt, remain);
    end
  endtask

  task automatic test_empty();
    out_ready = 1'b1;
    kick(8'h00);
    tests++;
    if (out_valid !== 1'b0 || done !== 1'b1 || grant_cnt !== 4'd0 || remain !== 8'h00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL empty_done got v=%b done=%b cnt=%0d rem=%h busy=%b want v=0 done=1 cnt=0 rem=00 busy=1",
               out_valid, done, grant_cnt, remain, busy);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_after got v=%b done=%b busy=%b want 0 0 0", out_valid, done, busy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    kick(8'h81);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_pos !== 3'd7) begin
        fails++;
        $display("FAIL stall%0d got v=%b pos=%0d want v=1 pos=7", i, out_valid, out_pos);
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b1 || out_pos !== 3'd7) begin
      fails++;
      $display("FAIL stall_release got v=%b pos=%0d want v=1 pos=7", out_valid, out_pos);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pos !== 3'd0) begin
      fails++;
      $display("FAIL stall_second got v=%b pos=%0d want v=1 pos=0", out_valid, out_pos);
    end
    step();
    tests++;
    if (done !== 1'b1 || grant_cnt !== 4'd2 || remain !== 8'h00) begin
      fails++;
      $display("FAIL stall_done got done=%b cnt=%0d rem=%h want done=1 cnt=2 rem=00", done, grant_cnt, remain);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    logic [2:0] exp_pos [3] = '{3'd7, 3'd6, 3'd5};
    out_ready = 1'b1;
    kick(8'hFF);
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      req   = (i == 0) ? 8'h01 : 8'h00;
      tests++;
      if (out_valid !== 1'b1 || out_pos !== exp_pos[i]) begin
        fails++;
        $display("FAIL busy_grant%0d got v=%b pos=%0d want v=1 pos=%0d", i, out_valid, out_pos, exp_pos[i]);
      end
      step();
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || grant_cnt !== 4'd3 || remain !== 8'h1F) begin
      fails++;
      $display("FAIL busy_done got done=%b cnt=%0d rem=%h want done=1 cnt=3 rem=1f", done, grant_cnt, remain);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    kick(8'hF0);
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pos !== 3'd6) begin
      fails++;
      $display("FAIL flush_pre got v=%b pos=%0d want v=1 pos=6", out_valid, out_pos);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle got busy=%b done=%b v=%b want 0 0 0", busy, done, out_valid);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_nodone got done=%b busy=%b want 0 0", done, busy);
    end
    // flush with start in IDLE drops the start.
    flush = 1'b1;
    kick(8'hFF);
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_start got busy=%b v=%b want 0 0", busy, out_valid);
    end
    // A fresh start after the abort works normally.
    kick(8'h0C);
    tests++;
    if (out_valid !== 1'b1 || out_pos !== 3'd3) begin
      fails++;
      $display("FAIL restart_g0 got v=%b pos=%0d want v=1 pos=3", out_valid, out_pos);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pos !== 3'd2) begin
      fails++;
      $display("FAIL restart_g1 got v=%b pos=%0d want v=1 pos=2", out_valid, out_pos);
    end
    step();
    tests++;
    if (done !== 1'b1 || grant_cnt !== 4'd2 || remain !== 8'h00) begin
      fails++;
      $display("FAIL restart_done got done=%b cnt=%0d rem=%h want done=1 cnt=2 rem=00", done, grant_cnt, remain);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    kick(8'hFF);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_pos, busy, done, grant_cnt, remain} !== 18'd0) begin
      fails++;
      $display("FAIL async_reset got v=%b pos=%0d busy=%b done=%b cnt=%0d rem=%h want all 0",
               out_valid, out_pos, busy, done, grant_cnt, remain);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

`ifdef MSB_SCHED_ONEHOT_EN
  task automatic test_onehot();
    out_ready = 1'b0;
    kick(8'h90);
    tests++;
    if (out_onehot !== 8'h80) begin
      fails++;
      $display("FAIL onehot0 got %h want 80", out_onehot);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_onehot !== 8'h10) begin
      fails++;
      $display("FAIL onehot1 got %h want 10", out_onehot);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin
      fails++;
      $display("FAIL onehot_idle got v=%b oh=%h want v=0 oh=00", out_valid, out_onehot);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_start_while_busy();
    test_flush();
    test_async_reset();
`ifdef MSB_SCHED_ONEHOT_EN
    test_onehot();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
